card_dealer: RTL
================

# card_dealer

- Upstream stage of the blackjack hand FSM.
- Models a single 52-card deck with no replacement, driven by a free-running LFSR.
- Keeps one pre-drawn card staged for the player and one for the dealer. The FSM's draw events consume them through take pulses.
- Tracks dealt cards so no card repeats until a shuffle or reset.

## Interface
Parameters:
- DECK_SIZE, 52, number of cards; index 0..51, rank = index mod 13.
- LFSR_SEED, 8'h01, LFSR load value on reset; must be non-zero.

Ports:
- Clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- take_p  in  1  one-cycle pulse: player card consumed.
- take_d  in  1  one-cycle pulse: dealer card consumed.
- shuffle  in  1  one-cycle pulse: return all cards to the deck.
- pcard  out  5  staged player card value, 1..10; 0 when not ready.
- dcard  out  5  staged dealer card value, 1..10; 0 when not ready.
- pready  out  1  pcard holds a valid card.
- dready  out  1  dcard holds a valid card.
- cards_left  out  6  cards not yet dealt, 0..52.
- deck_empty  out  1  high while a slot needs a card and cards_left==0.

## Operation
- **LFSR:** 8-bit Fibonacci register.
  - Shifts left every non-reset cycle: next = {q[6:0], q[7]^q[5]^q[4]^q[3]}.
  - Candidate index is q[5:0].
- **Value map:** rank r = idx mod 13; value = r+1 for r<=9, 10 for r=10..12 (ace=1, J/Q/K=10).
- **dealt mask:** 52 bits; bit set when that card is staged.
- **States:** IDLE (both slots ready), FILL (at least one slot empty), EMPTY.
- **FILL:** each cycle tests the current candidate.
  - Reject if idx>=52 or dealt[idx]=1; retry next cycle with the next LFSR value.
  - On accept: set dealt[idx], decrement cards_left, write value to the target slot and set its ready flag.
  - Target is the player slot if !pready, else the dealer slot.
  - Go to IDLE if both slots are then ready; else stay in FILL.
- **take_x:**
  - With ready_x=1, in any state: clear ready_x and card_x the next cycle; state becomes FILL (or EMPTY if cards_left==0).
  - With ready_x=0: ignored.
  - take_p and take_d together: both cleared; player slot refilled first.
- **EMPTY:**
  - deck_empty=1.
  - Staged cards stay valid and takeable.
  - Held until shuffle or reset.
- **shuffle:**
  - Clears the dealt mask, both ready flags and both cards.
  - Sets cards_left=52; state goes to FILL.
  - LFSR is not reloaded.
  - take pulses in the same cycle are ignored.
- **Priority:** reset > shuffle > take > fill.

## Timing
- **Reset values:** pcard=0, dcard=0, pready=0, dready=0, cards_left=52, deck_empty=0, dealt=0, lfsr=LFSR_SEED, state=FILL.
- **Accept latency:** a card accepted in cycle N is visible (card_x, ready_x, cards_left) after the edge ending cycle N.
- **take latency:** take_x sampled at edge E clears ready_x after E. The first candidate for refill is tested in the cycle after E.
- **Refill bound:** the LFSR period of 255 covers all 64 low-6-bit patterns, so refill completes in <=255 cycles while undealt cards remain.
- **Idle LFSR:** the LFSR advances in every state, including IDLE. Card choice therefore depends on when the human presses.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared constants live in a common header: DECK_SIZE=52, RANKS=13, FACE_VALUE=10, MAX_HAND=21, state encodings.
- One sub-module, lfsr8, holding the shift register with seed load and enable.
- Rank-to-value mapping is a local function.

## Test plan
- Reset, then run free:
  - First cycle, lfsr=0x01, idx 1 → pcard=2, pready=1.
  - Next cycle, lfsr=0x02, idx 2 → dcard=3, dready=1.
  - cards_left=50, state IDLE.
- From that point, take_p in the cycle lfsr=0x04:
  - pready=0 after the edge.
  - Next cycle lfsr=0x08, idx 8 → pcard=9; cards_left=49.
- Simultaneous take_p and take_d:
  - Both readies drop together.
  - Player refilled strictly before dealer; cards_left drops by 2.
- Draw 52 cards via repeated take pulses:
  - All indices are distinct and no idx>=52 is ever accepted.
  - cards_left reaches 0 and deck_empty=1 on the next take.
  - Further takes are ignored.
- shuffle while in EMPTY: deck_empty=0, cards_left=52, both slots refilled.
- reset asserted mid-FILL in the same cycle as take_p: all outputs return to reset values.

Source files
------------

// File: rtl/card_dealer_pkg.sv
// Shared constants for the card dealer and the blackjack hand logic around it.
package card_dealer_pkg;

    localparam int DECK_SIZE  = 52;
    localparam int RANKS      = 13;
    localparam int FACE_VALUE = 10;
    localparam int MAX_HAND   = 21;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_EMPTY = 2'd2;

endpackage

// File: rtl/card_dealer_lfsr8.sv
// 8-bit Fibonacci LFSR used as the card picker. It runs freely so card
// choice depends on when the player acts. Only the low six bits leave the
// block because they form the candidate card index.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [5:0] candidate
);

    logic [7:0] q;

    // Load the seed on reset, otherwise shift left with feedback from taps 7,5,4,3
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= SEED;
        end else if (enable) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

    assign candidate = q[5:0];

endmodule

// File: rtl/card_dealer.sv
// Deck model without replacement: keeps one staged card for the player and
// one for the dealer, refilling empty slots from LFSR-chosen undealt cards.
module card_dealer #(
    parameter int         DECK_SIZE = card_dealer_pkg::DECK_SIZE,
    parameter logic [7:0] LFSR_SEED = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       take_p,
    input  logic       take_d,
    input  logic       shuffle,
    output logic [4:0] pcard,
    output logic [4:0] dcard,
    output logic       pready,
    output logic       dready,
    output logic [5:0] cards_left,
    output logic       deck_empty
);

    import card_dealer_pkg::*;

    logic [1:0]           state;
    logic [DECK_SIZE-1:0] dealt;
    logic [5:0]           cand_idx;
    logic [63:0]          dealt_ext;
    logic [63:0]          pick_mask;
    logic                 cand_ok;
    logic [4:0]           cand_val;
    logic                 take_hit;

    // Map a card index to its blackjack value: ace=1, 2..10 face value, J/Q/K=10
    function automatic logic [4:0] card_value(input logic [5:0] idx);
        logic [5:0] rank;
        rank = idx % 6'(RANKS);
        if (int'(rank) < FACE_VALUE) begin
            card_value = 5'(rank) + 5'd1;
        end else begin
            card_value = 5'(FACE_VALUE);
        end
    endfunction

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .enable    (1'b1),
        .candidate (cand_idx)
    );

    // Candidate is usable only if it names a real card that has not been dealt
    always_comb begin
        dealt_ext = 64'(dealt);
        pick_mask = 64'd1 << cand_idx;
        cand_ok   = (cand_idx < 6'(DECK_SIZE)) && !dealt_ext[cand_idx];
        cand_val  = card_value(cand_idx);
        take_hit  = (take_p && pready) || (take_d && dready);
    end

    // Deck bookkeeping and slot refill; reset beats shuffle beats take beats fill
    always_ff @(posedge clk) begin
        if (reset) begin
            pcard      <= 5'd0;
            dcard      <= 5'd0;
            pready     <= 1'b0;
            dready     <= 1'b0;
            cards_left <= 6'(DECK_SIZE);
            dealt      <= '0;
            state      <= ST_FILL;
        end else if (shuffle) begin
            pcard      <= 5'd0;
            dcard      <= 5'd0;
            pready     <= 1'b0;
            dready     <= 1'b0;
            cards_left <= 6'(DECK_SIZE);
            dealt      <= '0;
            state      <= ST_FILL;
        end else if (take_hit) begin
            if (take_p && pready) begin
                pready <= 1'b0;
                pcard  <= 5'd0;
            end
            if (take_d && dready) begin
                dready <= 1'b0;
                dcard  <= 5'd0;
            end
            state <= (cards_left == 6'd0) ? ST_EMPTY : ST_FILL;
        end else if (state == ST_FILL) begin
            if (cards_left == 6'd0) begin
                state <= ST_EMPTY;
            end else if (cand_ok) begin
                dealt      <= dealt | pick_mask[DECK_SIZE-1:0];
                cards_left <= cards_left - 6'd1;
                if (!pready) begin
                    pcard  <= cand_val;
                    pready <= 1'b1;
                    if (dready) begin
                        state <= ST_IDLE;
                    end else if (cards_left == 6'd1) begin
                        state <= ST_EMPTY;
                    end
                end else begin
                    dcard  <= cand_val;
                    dready <= 1'b1;
                    state  <= ST_IDLE;
                end
            end
        end
    end

    assign deck_empty = (state == ST_EMPTY);

endmodule
